icache_fill: RTL and testbench
==============================

Name: icache_fill

Overview:
- Instruction-side responder for the fetch PC: returns the 32-bit instruction at `PC` from a direct-mapped instruction cache.
- On a miss, raises `stall` and refills one line from backing memory through a request/valid word interface.
- Sits between the PC register stage and main memory.
- Hits are combinational, so single-cycle fetch is preserved.

Parameters:
- NUM_SETS, 16, number of lines; power of two, ≥2.
- WORDS_PER_LINE, 4, 32-bit words per line; power of two, ≥2.
- ADDR_W, 32, byte address width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- PC  in  ADDR_W  fetch byte address; bits [1:0] ignored
- flush  in  1  invalidate all lines (fence.i)
- instr  out  32  instruction at PC; valid only when stall=0
- stall  out  1  high while instr is not yet valid; the core must hold PC
- mem_req  out  1  refill request, registered
- mem_addr  out  ADDR_W  word-aligned refill address, registered
- mem_valid  in  1  memory returns one word this cycle
- mem_rdata  in  32  returned word

Behaviour:
- Address split:
  - OFF = log2(WORDS_PER_LINE)+2 bits
  - IDX = log2(NUM_SETS) bits
  - TAG = ADDR_W−OFF−IDX bits (24 at defaults)
- Storage: data array, tag array, valid bit per line.
- hit = valid[idx] & (tag[idx]==PC tag) & state==IDLE.
- instr = data[idx][word]; stall = ~hit.
- While rst is high: stall=0, instr=0.
- Reset (asynchronous):
  - all valid bits = 0; state = IDLE; mem_req = 0; mem_addr = 0; beat counter = 0.
  - Tag and data arrays are not reset.
- FSM IDLE:
  - If hit, or rst was deasserted this cycle: stay.
  - On miss: latch line base (PC with offset zeroed) into miss_addr.
  - Next edge: go to REFILL, mem_req=1, mem_addr=miss_addr, beat=0.
- FSM REFILL:
  - mem_req and mem_addr are held stable until mem_valid is sampled high.
  - Each edge with mem_valid=1: write mem_rdata into data[miss_idx][beat]; beat++; mem_addr += 4.
  - On the final beat (beat==WORDS_PER_LINE−1):
    - write tag[miss_idx]; set valid[miss_idx]=1 unless flush_pend.
    - Go to IDLE; mem_req=0 on the same edge.
  - mem_valid while mem_req=0 is ignored.
- Latency:
  - Miss detected in cycle 0; REFILL occupies cycles 1..N.
  - With mem_valid held high, N = WORDS_PER_LINE.
  - Hit in cycle N+1, so stall is high for WORDS_PER_LINE+1 cycles.
- Boundaries:
  - PC changing during REFILL: the refill completes for the latched line; IDLE then re-looks-up the current PC.
  - A miss-replaced line evicts the old tag silently (instructions are read-only, no writeback).
  - mem_addr wraps modulo 2^ADDR_W. Refill order is always word 0 to word N−1; no critical-word-first.
- flush:
  - In IDLE: all valid bits are cleared at the edge. hit is forced 0 during the flush cycle, so stall=1.
  - In REFILL: sets flush_pend. The line is written but left invalid; all valid bits clear at REFILL exit; flush_pend clears.
- Reset mid-refill: refill aborts immediately, mem_req=0, no line is marked valid. Memory must discard any outstanding beat.

Optional Feature:
- ICACHE_STATS_EN defined:
  - Adds ports hit_count out 32 and miss_count out 32, both reset to 0.
  - hit_count increments on each cycle with hit=1.
  - miss_count increments on each IDLE→REFILL transition.
  - Both counters saturate at 0xFFFFFFFF.
- Not defined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package icache_pkg holds:
  - typedef enum {IDLE, REFILL} fill_state_t
  - localparam helper functions for OFF/IDX/TAG widths
  - struct addr_fields_t {tag, idx, word}
- One sub-module, icache_line_store: tag/valid/data arrays with a combinational read port and a registered write port.
- The FSM and address logic stay in icache_fill.

Test Plan:
- Cold miss, PC=0x0, mem_valid always 1, words 0x11,0x22,0x33,0x44:
  - stall high for 5 cycles; mem_addr 0x0,0x4,0x8,0xC.
  - Then instr=0x11, stall=0.
  - Then PC=0xC gives instr=0x44 with no stall.
- Conflict: after the above, PC=0x100 (same idx 0, different tag) → refill from 0x100; return to PC=0x0 → miss again.
- Slow memory: mem_valid high only every 3rd cycle → mem_addr holds each word until accepted; stall ends one cycle after the 4th accepted beat.
- Reset asserted during beat 2 of a refill → mem_req=0 asynchronously; after release, PC=0x0 misses (line not valid).
- flush during REFILL → the line completes but PC=0x0 still misses afterwards; flush in IDLE with a hit → stall=1 that cycle, then a refill.
- ICACHE_STATS_EN: cold miss plus 3 hits → miss_count=1, hit_count=3.

Source files
------------

// File: rtl/icache_pkg.sv
// icache_pkg: shared state encoding, address-field record and width helpers
// for the instruction-cache fill block.
package icache_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } fill_state_t;

    // Address fields are carried zero-extended in a fixed-width record so the
    // type does not depend on the cache geometry; users slice the low bits.
    localparam int unsigned FIELD_W = 64;

    typedef struct packed {
        logic [FIELD_W-1:0] tag;
        logic [FIELD_W-1:0] idx;
        logic [FIELD_W-1:0] word;
    } addr_fields_t;

    function automatic int unsigned word_width(input int unsigned words_per_line);
        return $clog2(words_per_line);
    endfunction

    function automatic int unsigned off_width(input int unsigned words_per_line);
        return $clog2(words_per_line) + 2;
    endfunction

    function automatic int unsigned idx_width(input int unsigned num_sets);
        return $clog2(num_sets);
    endfunction

    function automatic int unsigned tag_width(input int unsigned addr_w,
                                              input int unsigned num_sets,
                                              input int unsigned words_per_line);
        return addr_w - off_width(words_per_line) - idx_width(num_sets);
    endfunction

endpackage

// File: rtl/icache_line_store.sv
// icache_line_store: tag, valid and data arrays of the direct-mapped cache.
// Combinational read port; registered write port. Only the valid bits reset.
module icache_line_store
    import icache_pkg::*;
#(
    parameter int unsigned NUM_SETS       = 16,
    parameter int unsigned WORDS_PER_LINE = 4,
    parameter int unsigned IDX_W          = 4,
    parameter int unsigned WORD_W         = 2,
    parameter int unsigned TAG_W          = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  rd_idx,
    input  logic [WORD_W-1:0] rd_word,
    output logic [TAG_W-1:0]  rd_tag,
    output logic              rd_valid,
    output logic [31:0]       rd_data,
    input  logic              data_we,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [WORD_W-1:0] wr_word,
    input  logic [31:0]       wr_data,
    input  logic              tag_we,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic              set_valid,
    input  logic              clear_all
);

    logic [31:0]      data_mem [NUM_SETS][WORDS_PER_LINE];
    logic [TAG_W-1:0] tag_mem  [NUM_SETS];
    logic [NUM_SETS-1:0] valid_q;

    assign rd_data  = data_mem[rd_idx][rd_word];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_valid = valid_q[rd_idx];

    // Data and tag writes from the refill engine; contents are not reset.
    always_ff @(posedge clk) begin
        if (data_we) begin
            data_mem[wr_idx][wr_word] <= wr_data;
        end
        if (tag_we) begin
            tag_mem[wr_idx] <= wr_tag;
        end
    end

    // Valid bits: bulk clear takes priority over marking a freshly filled line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (clear_all) begin
            valid_q <= '0;
        end else if (set_valid) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

endmodule

// File: rtl/icache_fill.sv
// icache_fill: direct-mapped instruction cache with single-line refill engine.
// Hits return combinationally; misses stall while the line is fetched word
// by word over a req/valid memory interface.
// Optional macro ICACHE_STATS_EN adds saturating hit_count/miss_count ports.
module icache_fill
    import icache_pkg::*;
#(
    parameter int unsigned NUM_SETS       = 16,
    parameter int unsigned WORDS_PER_LINE = 4,
    parameter int unsigned ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] PC,
    input  logic              flush,
    output logic [31:0]       instr,
    output logic              stall,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_valid,
    input  logic [31:0]       mem_rdata
`ifdef ICACHE_STATS_EN
   ,output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`endif
);

    localparam int unsigned OFF_W     = off_width(WORDS_PER_LINE);
    localparam int unsigned IDX_W     = idx_width(NUM_SETS);
    localparam int unsigned TAG_W     = tag_width(ADDR_W, NUM_SETS, WORDS_PER_LINE);
    localparam int unsigned WORD_W    = word_width(WORDS_PER_LINE);
    localparam int unsigned LAST_BEAT = WORDS_PER_LINE - 1;

    function automatic addr_fields_t split_addr(input logic [ADDR_W-1:0] a);
        addr_fields_t f;
        f      = '0;
        f.tag  = FIELD_W'(a[ADDR_W-1:OFF_W+IDX_W]);
        f.idx  = FIELD_W'(a[OFF_W+IDX_W-1:OFF_W]);
        f.word = FIELD_W'(a[OFF_W-1:2]);
        return f;
    endfunction

    fill_state_t       state, state_nx;
    logic [ADDR_W-1:0] miss_addr;
    logic [ADDR_W-1:0] line_base;
    logic [WORD_W-1:0] beat;
    logic              flush_pend;
    logic              boot;
    addr_fields_t      pc_f, miss_f;

    logic [TAG_W-1:0]  rd_tag;
    logic              rd_valid;
    logic [31:0]       rd_data;
    logic              hit;
    logic              miss_start;
    logic              beat_acc;
    logic              last_beat;
    logic              tag_we;
    logic              set_valid;
    logic              clear_all;

    assign pc_f      = split_addr(PC);
    assign miss_f    = split_addr(miss_addr);
    assign line_base = {PC[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

    assign hit   = ~rst & ~flush & (state == IDLE) & rd_valid
                 & (rd_tag == pc_f.tag[TAG_W-1:0]);
    assign stall = ~rst & ~hit;
    assign instr = rst ? '0 : rd_data;

    icache_line_store #(
        .NUM_SETS       (NUM_SETS),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .IDX_W          (IDX_W),
        .WORD_W         (WORD_W),
        .TAG_W          (TAG_W)
    ) u_store (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (pc_f.idx[IDX_W-1:0]),
        .rd_word   (pc_f.word[WORD_W-1:0]),
        .rd_tag    (rd_tag),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .data_we   (beat_acc),
        .wr_idx    (miss_f.idx[IDX_W-1:0]),
        .wr_word   (beat),
        .wr_data   (mem_rdata),
        .tag_we    (tag_we),
        .wr_tag    (miss_f.tag[TAG_W-1:0]),
        .set_valid (set_valid),
        .clear_all (clear_all)
    );

    // Next-state and array-control decode for the refill FSM.
    always_comb begin
        state_nx   = state;
        miss_start = 1'b0;
        beat_acc   = 1'b0;
        last_beat  = 1'b0;
        tag_we     = 1'b0;
        set_valid  = 1'b0;
        clear_all  = 1'b0;
        case (state)
            IDLE: begin
                if (flush) begin
                    clear_all = 1'b1;
                end
                // The first cycle after reset release never launches a refill.
                if (!hit && !boot) begin
                    miss_start = 1'b1;
                    state_nx   = REFILL;
                end
            end
            REFILL: begin
                if (mem_valid) begin
                    beat_acc = 1'b1;
                    if (beat == WORD_W'(LAST_BEAT)) begin
                        last_beat = 1'b1;
                        tag_we    = 1'b1;
                        // A flush seen anywhere in the refill, including this
                        // final edge, leaves the line invalid and wipes all sets.
                        set_valid = ~(flush_pend | flush);
                        clear_all = flush_pend | flush;
                        state_nx  = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register, refill address/beat tracking and pending-flush flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            miss_addr  <= '0;
            beat       <= '0;
            flush_pend <= 1'b0;
            boot       <= 1'b1;
        end else begin
            state <= state_nx;
            boot  <= 1'b0;
            if (miss_start) begin
                miss_addr <= line_base;
                mem_req   <= 1'b1;
                mem_addr  <= line_base;
                beat      <= '0;
            end
            if (state == REFILL) begin
                if (flush) begin
                    flush_pend <= 1'b1;
                end
                if (beat_acc) begin
                    beat     <= beat + 1'b1;
                    mem_addr <= mem_addr + ADDR_W'(4);
                end
                if (last_beat) begin
                    mem_req    <= 1'b0;
                    flush_pend <= 1'b0;
                end
            end
        end
    end

`ifdef ICACHE_STATS_EN
    // Saturating hit and miss counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit && (hit_count != '1)) begin
                hit_count <= hit_count + 32'd1;
            end
            if (miss_start && (miss_count != '1)) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_fill.sv
// tb_icache_fill: scoreboard bench for icache_fill. Expected instructions and
// refill addresses are queued when a fetch is launched and retired as the DUT
// delivers them. Define ICACHE_STATS_EN to also check the counters.
module tb_icache_fill;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PC;
    logic        flush;
    logic [31:0] instr;
    logic        stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_valid;
    logic [31:0] mem_rdata;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    int          t0     = 0;
    logic        slow_mode = 1'b0;
    logic [31:0] instr_q[$];
    logic [31:0] addr_q[$];

    icache_fill #(
        .NUM_SETS       (16),
        .WORDS_PER_LINE (4),
        .ADDR_W         (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .PC         (PC),
        .flush      (flush),
        .instr      (instr),
        .stall      (stall),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_valid  (mem_valid),
        .mem_rdata  (mem_rdata)
`ifdef ICACHE_STATS_EN
       ,.hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Backing-memory contents: 0x11..0x44 in the first line, a tagged pattern elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = {30'd0, a[3:2]} + 32'd1;
        if (a < 32'h10) return 32'h11 * w;
        return {16'hBEEF, a[15:0]};
    endfunction

    task automatic push_line(input logic [31:0] base);
        for (int i = 0; i < 4; i++) addr_q.push_back(base + 32'(4 * i));
    endtask

    // Launch a fetch at posedge+1; refills = number of line refills expected.
    task automatic start_fetch(input logic [31:0] pc, input int refills);
        PC = pc;
        t0 = cyc;
        for (int i = 0; i < refills; i++) push_line(pc & ~32'hF);
        instr_q.push_back(mem_word(pc & ~32'h3));
    endtask

    // Wait (bounded) for stall to drop and check how many cycles it stayed high.
    task automatic wait_ready(input string tag, input int exp_cycles);
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            #1;
            if (!stall) break;
        end
        if (stall) check_eq({tag, "_timeout"}, {31'd0, stall}, 32'd0);
        else       check_eq(tag, 32'(cyc - t0), 32'(exp_cycles));
        @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Memory responder and output monitor, both on the falling edge.
    initial begin
        int slow_cnt;
        slow_cnt  = 0;
        mem_valid = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!mem_req) slow_cnt = 0;
            else          slow_cnt++;
            mem_valid = slow_mode ? (slow_cnt != 0 && (slow_cnt % 3) == 0) : 1'b1;
            mem_rdata = mem_word(mem_addr);
            if (!rst) begin
                if (mem_req) begin
                    if (addr_q.size() == 0)
                        check_eq("unexpected_req", {31'd0, mem_req}, 32'd0);
                    else if (mem_valid)
                        check_eq("mem_addr", mem_addr, addr_q.pop_front());
                    else
                        check_eq("mem_addr_hold", mem_addr, addr_q[0]);
                end
                if (!stall && instr_q.size() > 0)
                    check_eq("instr", instr, instr_q.pop_front());
            end
        end
    end

    initial begin
        rst   = 1'b1;
        PC    = 32'h0;
        flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_stall",    {31'd0, stall},   32'd0);
        check_eq("rst_instr",    instr,            32'd0);
        check_eq("rst_mem_req",  {31'd0, mem_req}, 32'd0);
        check_eq("rst_mem_addr", mem_addr,         32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Cold miss, then a hit elsewhere in the same line.
        start_fetch(32'h0, 1);  wait_ready("cold_miss", 5);
        start_fetch(32'hC, 0);  wait_ready("hit_0xC", 0);

        // Conflict on set 0.
        start_fetch(32'h100, 1); wait_ready("conflict_100", 5);
        start_fetch(32'h0, 1);   wait_ready("conflict_back_0", 5);

        // Fill set 1 so the flush below has another valid line to wipe.
        start_fetch(32'h10, 1);  wait_ready("fill_0x10", 5);
        start_fetch(32'h14, 0);  wait_ready("hit_0x14", 0);

        // Flush during refill: line completes invalid, so the same PC refills again.
        start_fetch(32'h200, 2);
        @(posedge clk); #1; flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        wait_ready("flush_in_refill", 10);
        start_fetch(32'h10, 1);  wait_ready("after_flush_0x10", 5);

        // Flush in IDLE over a hitting PC forces a stall and a refill.
        start_fetch(32'h10, 1);
        flush = 1'b1;
        @(negedge clk); #1;
        check_eq("flush_idle_stall", {31'd0, stall}, 32'd1);
        @(posedge clk); #1; flush = 1'b0;
        wait_ready("flush_idle_refill", 5);

        // Slow memory: a beat is accepted every third refill cycle.
        slow_mode = 1'b1;
        start_fetch(32'h300, 1); wait_ready("slow_mem", 13);
        slow_mode = 1'b0;

        // Reset during beat 2 of a refill aborts it.
        start_fetch(32'h0, 1);
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        check_eq("midrst_mem_req",  {31'd0, mem_req}, 32'd0);
        check_eq("midrst_mem_addr", mem_addr,         32'd0);
        check_eq("midrst_stall",    {31'd0, stall},   32'd0);
        check_eq("midrst_instr",    instr,            32'd0);
        instr_q.delete();
        addr_q.delete();
        release_reset();

        start_fetch(32'h0, 1);  wait_ready("post_rst_miss", 5);
        start_fetch(32'h4, 0);  wait_ready("hit_0x4", 0);
        start_fetch(32'h8, 0);  wait_ready("hit_0x8", 0);
`ifdef ICACHE_STATS_EN
        // One miss since reset and three hit cycles (post-refill, 0x4, 0x8).
        check_eq("miss_count", miss_count, 32'd1);
        check_eq("hit_count",  hit_count,  32'd3);
`endif

        check_eq("addr_q_drained",  32'(addr_q.size()),  32'd0);
        check_eq("instr_q_drained", 32'(instr_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
